mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter_pkg.sv | 19 +
 rtl/mem_arb_pick.sv | 16 +
 rtl/mem_bus_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and width defaults for the instruction/data RAM arbiter.
// Optional build macro used by the arbiter: MEMARB_STARVE_GUARD_EN.
package mem_bus_arbiter_pkg;

    localparam int MEMARB_ADDR_W = 32;
    localparam int MEMARB_DATA_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCESS   = 2'd1,
        ST_COMPLETE = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Priority decision between fetch and data requesters.
// Data wins unless the starve guard forces a fetch.
module mem_arb_pick
    import mem_bus_arbiter_pkg::*;
(
    input  logic    if_req_i,
    input  logic    d_req_i,
    input  logic    force_if_i,
    output logic    pick_valid_o,
    output req_id_e pick_id_o
);

    assign pick_valid_o = if_req_i | d_req_i;
    assign pick_id_o    = (d_req_i && !force_if_i) ? REQ_D : REQ_IF;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester single-port RAM arbiter: IDLE -> ACCESS -> COMPLETE, one access per 2 cycles.
// Build macro MEMARB_STARVE_GUARD_EN adds a starve counter that forces a fetch after STARVE_LIMIT data grants.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W       = MEMARB_ADDR_W,
    parameter int DATA_W       = MEMARB_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              RST,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              ram_cs,
    output logic              ram_we,
    output logic              ram_oe,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    localparam logic [1:0] S_IDLE     = ST_IDLE;
    localparam logic [1:0] S_ACCESS   = ST_ACCESS;
    localparam logic [1:0] S_COMPLETE = ST_COMPLETE;

    logic [1:0]        state_q, state_d;
    req_id_e           win_q, win_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic    arb_en;
    logic    in_access;
    logic    in_complete;
    logic    force_if;
    logic    pick_valid;
    req_id_e pick_id;

    assign arb_en = (state_q == S_IDLE) || (state_q == S_COMPLETE);

    mem_arb_pick u_pick (
        .if_req_i     (if_req),
        .d_req_i      (d_req),
        .force_if_i   (force_if),
        .pick_valid_o (pick_valid),
        .pick_id_o    (pick_id)
    );

`ifdef MEMARB_STARVE_GUARD_EN
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_q, starve_d;

    assign force_if = if_req && (starve_q == CNT_MAX);

    always_comb begin
        starve_d = starve_q;
        if (!if_req) begin
            starve_d = '0;
        end else if (arb_en && pick_valid) begin
            if (pick_id == REQ_IF) begin
                starve_d = '0;
            end else if (starve_q != CNT_MAX) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!RST) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign force_if = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        case (state_q)
            S_ACCESS: state_d = S_COMPLETE;
            S_IDLE, S_COMPLETE: begin
                // COMPLETE is also the capture cycle for read data
                if ((state_q == S_COMPLETE) && !we_q) begin
                    if (win_q == REQ_IF) begin
                        if_rdata_d = ram_rdata;
                    end else begin
                        d_rdata_d = ram_rdata;
                    end
                end
                if (pick_valid) begin
                    state_d = S_ACCESS;
                    win_d   = pick_id;
                    if (pick_id == REQ_D) begin
                        we_d    = d_we;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                    end else begin
                        we_d    = 1'b0;
                        addr_d  = if_addr;
                        wdata_d = '0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            win_q      <= REQ_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign in_access   = (state_q == S_ACCESS);
    // A reset arriving in COMPLETE aborts the access, so done is suppressed
    assign in_complete = (state_q == S_COMPLETE) && RST;

    assign ram_cs    = in_access;
    assign ram_we    = in_access && we_q;
    assign ram_oe    = in_access && !we_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;

    assign if_gnt  = in_access && (win_q == REQ_IF);
    assign d_gnt   = in_access && (win_q == REQ_D);
    assign if_done = in_complete && (win_q == REQ_IF);
    assign d_done  = in_complete && (win_q == REQ_D);

    // Bypass makes data valid alongside done; the register holds it afterwards
    assign if_rdata = if_done ? ram_rdata : if_rdata_q;
    assign d_rdata  = (d_done && !we_q) ? ram_rdata : d_rdata_q;

    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter with a behavioural RAM and reference memory.
module tb_mem_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 64;

    logic          clock = 1'b0;
    logic          RST = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt, if_done;
    logic [DW-1:0] if_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_gnt, d_done;
    logic [DW-1:0] d_rdata;
    logic          ram_cs, ram_we, ram_oe;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;
    logic          busy;

    mem_bus_arbiter dut (
        .clock     (clock),
        .RST       (RST),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_done   (if_done),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_done    (d_done),
        .d_rdata   (d_rdata),
        .ram_cs    (ram_cs),
        .ram_we    (ram_we),
        .ram_oe    (ram_oe),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [63:0] init_word(input int i);
        return {32'hC0DE_0000 + 32'(i), 32'(i * 13 + 5)};
    endfunction

    // Synchronous RAM: read data appears the cycle after the read access
    logic [DW-1:0] mem [128];
    logic          mem_ready = 1'b0;
    always @(posedge clock) begin
        if (!mem_ready) begin
            for (int i = 0; i < 128; i++) mem[i] <= init_word(i);
            mem_ready <= 1'b1;
        end else if (ram_cs) begin
            if (ram_we) mem[ram_addr[6:0]] <= ram_wdata;
            else if (ram_oe) ram_rdata <= mem[ram_addr[6:0]];
        end
    end

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } txn_t;

    logic [DW-1:0] ref_mem [128];
    logic [DW-1:0] last_d;
    txn_t          d_q[$];
    txn_t          if_q[$];
    int            total = 0;
    int            bad = 0;
    bit            mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: event missing or unexpected at cycle %0d", name, cyc);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic issue_d(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                           output int gcyc);
        txn_t t;
        int   n;
        t.we = we;
        t.addr = a;
        t.wdata = wd;
        if (we) begin
            ref_mem[a[6:0]] = wd;
            t.rdata = last_d;
        end else begin
            t.rdata = ref_mem[a[6:0]];
            last_d = t.rdata;
        end
        d_q.push_back(t);
        d_we = we;
        d_addr = a;
        d_wdata = wd;
        d_req = 1'b1;
        n = 0;
        gcyc = -1;
        while (n < 40) begin
            @(negedge clock);
            if (d_gnt) begin
                gcyc = cyc;
                break;
            end
            n++;
        end
        if (gcyc < 0) fail("d_gnt_timeout");
        @(posedge clock);
        #1;
        d_req = 1'b0;
    endtask

    task automatic issue_if(input logic [AW-1:0] a, output int gcyc);
        txn_t t;
        int   n;
        t.we = 1'b0;
        t.addr = a;
        t.wdata = '0;
        t.rdata = ref_mem[a[6:0]];
        if_q.push_back(t);
        if_addr = a;
        if_req = 1'b1;
        n = 0;
        gcyc = -1;
        while (n < 40) begin
            @(negedge clock);
            if (if_gnt) begin
                gcyc = cyc;
                break;
            end
            n++;
        end
        if (gcyc < 0) fail("if_gnt_timeout");
        @(posedge clock);
        #1;
        if_req = 1'b0;
    endtask

    // Monitor: checks every grant and done against the queued expectations
    initial begin
        txn_t t;
        logic pif, pd;
        pif = 1'b0;
        pd = 1'b0;
        forever begin
            @(negedge clock);
            if (mon_en) begin
                if (if_gnt || d_gnt) begin
                    chk("gnt_exclusive", 64'(if_gnt & d_gnt), 64'd0);
                    chk("ram_cs_with_gnt", 64'(ram_cs), 64'd1);
                end else if (ram_cs) begin
                    fail("ram_cs_without_gnt");
                end
                if (d_gnt) begin
                    if (d_q.size() == 0) fail("d_gnt_unexpected");
                    else begin
                        t = d_q[0];
                        chk("d_ram_addr", 64'(ram_addr), 64'(t.addr));
                        chk("d_ram_we", 64'(ram_we), 64'(t.we));
                        chk("d_ram_oe", 64'(ram_oe), 64'(!t.we));
                        if (t.we) chk("d_ram_wdata", ram_wdata, t.wdata);
                    end
                end
                if (if_gnt) begin
                    if (if_q.size() == 0) fail("if_gnt_unexpected");
                    else begin
                        t = if_q[0];
                        chk("if_ram_addr", 64'(ram_addr), 64'(t.addr));
                        chk("if_ram_oe", 64'(ram_oe), 64'd1);
                        chk("if_ram_we", 64'(ram_we), 64'd0);
                    end
                end
                if (d_done || pd) begin
                    chk("d_done_follows_gnt", 64'(d_done), 64'(pd));
                    if (d_done) begin
                        if (d_q.size() == 0) fail("d_done_unexpected");
                        else begin
                            t = d_q.pop_front();
                            chk("d_rdata", d_rdata, t.rdata);
                        end
                    end
                end
                if (if_done || pif) begin
                    chk("if_done_follows_gnt", 64'(if_done), 64'(pif));
                    if (if_done) begin
                        if (if_q.size() == 0) fail("if_done_unexpected");
                        else begin
                            t = if_q.pop_front();
                            chk("if_rdata", if_rdata, t.rdata);
                        end
                    end
                end
            end
            pif = if_gnt;
            pd = d_gnt;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int   c0, g1, g2, k, n;
        logic exp_if;
        for (int i = 0; i < 128; i++) ref_mem[i] = init_word(i);
        last_d = '0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ram_cs", 64'(ram_cs), 64'd0);
        chk("rst_ram_we", 64'(ram_we), 64'd0);
        chk("rst_ram_oe", 64'(ram_oe), 64'd0);
        chk("rst_if_gnt", 64'(if_gnt), 64'd0);
        chk("rst_d_gnt", 64'(d_gnt), 64'd0);
        chk("rst_if_done", 64'(if_done), 64'd0);
        chk("rst_d_done", 64'(d_done), 64'd0);
        chk("rst_ram_addr", 64'(ram_addr), 64'd0);
        chk("rst_ram_wdata", ram_wdata, 64'd0);
        chk("rst_if_rdata", if_rdata, 64'd0);
        chk("rst_d_rdata", d_rdata, 64'd0);
        @(posedge clock);
        #1;
        RST = 1'b1;
        mon_en = 1'b1;
        idle(1);

        // Lone fetch: grant one cycle after the request
        c0 = cyc;
        issue_if(32'h10, g1);
        chk("fetch_gnt_latency", 64'(g1 - c0), 64'd1);
        idle(3);
        @(negedge clock);
        chk("if_rdata_hold", if_rdata, init_word(16));
        @(posedge clock);
        #1;

        // Store then back-to-back load of the same word
        c0 = cyc;
        issue_d(1'b1, 32'h40, 64'hDEAD, g1);
        issue_d(1'b0, 32'h40, '0, g2);
        chk("store_gnt_latency", 64'(g1 - c0), 64'd1);
        chk("b2b_gnt_spacing", 64'(g2 - g1), 64'd2);
        idle(2);

        // Simultaneous requests: data first, fetch two cycles later
        fork
            issue_d(1'b0, 32'h41, '0, g1);
            issue_if(32'h11, g2);
        join
        chk("simul_if_after_d", 64'(g2 - g1), 64'd2);
        idle(2);

        fork
            begin : d_drv
                int   g;
                logic w;
                for (int i = 0; i < 25; i++) begin
                    w = 1'($urandom_range(0, 1));
                    issue_d(w, 32'(64 + $urandom_range(0, 63)), {$urandom, $urandom}, g);
                    idle($urandom_range(0, 2));
                end
            end
            begin : if_drv
                int g;
                for (int i = 0; i < 25; i++) begin
                    issue_if(32'($urandom_range(0, 63)), g);
                    idle($urandom_range(0, 2));
                end
            end
        join
        idle(3);
        chk("d_q_drained_rand", 64'(d_q.size()), 64'd0);
        chk("if_q_drained_rand", 64'(if_q.size()), 64'd0);

        // Both requesters held continuously
        mon_en = 1'b0;
        RST = 1'b0;
        idle(1);
        RST = 1'b1;
        d_we = 1'b0;
        d_addr = 32'd64;
        if_addr = 32'd0;
        d_req = 1'b1;
        if_req = 1'b1;
        k = 0;
        n = 0;
        while (k < 10 && n < 100) begin
            @(negedge clock);
            n++;
            if (d_gnt || if_gnt) begin
`ifdef MEMARB_STARVE_GUARD_EN
                exp_if = ((k % 5) == 4);
`else
                exp_if = 1'b0;
`endif
                chk($sformatf("starve_grant%0d", k), 64'(if_gnt), 64'(exp_if));
                k++;
            end
        end
        if (k < 10) fail("starve_grant_timeout");
        @(posedge clock);
        #1;
        d_req = 1'b0;
        if_req = 1'b0;
        idle(4);

        // Reset during ACCESS aborts the access
        RST = 1'b0;
        idle(1);
        RST = 1'b1;
        last_d = '0;
        d_we = 1'b0;
        d_addr = 32'd70;
        d_req = 1'b1;
        n = 0;
        while (n < 10 && !d_gnt) begin
            @(negedge clock);
            n++;
        end
        if (!d_gnt) fail("abort_d_gnt_timeout");
        RST = 1'b0;
        @(posedge clock);
        #1;
        d_req = 1'b0;
        RST = 1'b1;
        @(negedge clock);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_ram_cs", 64'(ram_cs), 64'd0);
        chk("abort_d_done", 64'(d_done), 64'd0);
        chk("abort_d_rdata", d_rdata, 64'd0);
        @(negedge clock);
        chk("abort_no_late_done", 64'(d_done), 64'd0);
        @(posedge clock);
        #1;
        mon_en = 1'b1;
        issue_d(1'b0, 32'd70, '0, g1);
        idle(3);
        chk("d_q_drained_end", 64'(d_q.size()), 64'd0);
        chk("if_q_drained_end", 64'(if_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
